// File: rtl/mem_stage_sram.sv
// mem_stage_sram
//   Pipeline MEM stage in front of a 16-bit asynchronous SRAM.
//   - Each 32-bit load or store is split into two halfword accesses:
//     LO first (bits [15:0]), then HI (bits [31:16]).
//   - While an access is in progress, the stage stalls everything upstream.
//   - During a stall, the output register carries bubbles.
//
// Ports
//   clk, rst               clock (rising edge); synchronous active-low reset
//   WB_En_in, MEM_R_En_in,
//   MEM_W_En_in            control bits from the EXE stage register
//   dest_in                destination register number
//   ALU_result_in          ALU result / byte address for loads and stores
//   readdata_in            store data
//   WB_En, MEM_R_En, dest,
//   ALU_result, mem_data   registered outputs towards write-back
//   freeze                 combinational stall request, 1 = hold upstream
//   SRAM_ADDR, SRAM_WE_N   SRAM halfword address, active-low write strobe
//   sram_dq_out, sram_dq_oe,
//   sram_dq_in             split bidirectional SRAM data bus
module mem_stage_sram (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_En_in,
  input  logic        MEM_R_En_in,
  input  logic        MEM_W_En_in,
  input  logic [4:0]  dest_in,
  input  logic [31:0] ALU_result_in,
  input  logic [31:0] readdata_in,
  output logic        WB_En,
  output logic        MEM_R_En,
  output logic [4:0]  dest,
  output logic [31:0] ALU_result,
  output logic [31:0] mem_data,
  output logic        freeze,
  output logic [17:0] SRAM_ADDR,
  output logic        SRAM_WE_N,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in
);

  typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_buf;
  logic        w_req;
  logic        w_is_wr;
  logic        w_is_rd;
  logic [16:0] w_word;

  // Simultaneous read and write requests are treated as a write.
  assign w_req   = MEM_R_En_in | MEM_W_En_in;
  assign w_is_wr = MEM_W_En_in;
  assign w_is_rd = MEM_R_En_in & ~MEM_W_En_in;

  // Word index is (addr - 1024)[18:2].
  // Subtracting 1024 never touches bits [1:0], so 256 is subtracted from
  // bits [18:2] directly. The result wraps modulo 2^17.
  assign w_word = ALU_result_in[18:2] - 17'd256;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_req ? S_LO : S_IDLE;
      S_LO:    w_next = S_HI;
      S_HI:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: stall request and SRAM bus.
  // All of them are forced inactive while reset is held.
  always_comb begin
    freeze      = 1'b0;
    SRAM_ADDR   = '0;
    SRAM_WE_N   = 1'b1;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    if (rst) begin
      case (r_state)
        S_IDLE: freeze = w_req;
        S_LO, S_HI: begin
          freeze    = 1'b1;
          SRAM_ADDR = {w_word, (r_state == S_HI)};
          if (w_is_wr) begin
            SRAM_WE_N   = 1'b0;
            sram_dq_oe  = 1'b1;
            sram_dq_out = (r_state == S_HI) ? readdata_in[31:16] : readdata_in[15:0];
          end
        end
        default: ;
      endcase
    end
  end

  // Load buffer.
  // The asynchronous SRAM data is valid within the cycle, so it is
  // captured at the end of LO (low half) and HI (high half).
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_buf <= '0;
    end else if (w_is_rd) begin
      if (r_state == S_LO) r_buf[15:0]  <= sram_dq_in;
      if (r_state == S_HI) r_buf[31:16] <= sram_dq_in;
    end
  end

  // Output register: a bubble is loaded while stalled.
  always_ff @(posedge clk) begin
    if (!rst || freeze) begin
      WB_En      <= 1'b0;
      MEM_R_En   <= 1'b0;
      dest       <= '0;
      ALU_result <= '0;
      mem_data   <= '0;
    end else begin
      WB_En      <= WB_En_in;
      MEM_R_En   <= MEM_R_En_in;
      dest       <= dest_in;
      ALU_result <= ALU_result_in;
      mem_data   <= (r_state == S_DONE && w_is_rd) ? r_buf : '0;
    end
  end

endmodule

// File: tb/tb_mem_stage_sram.sv
module tb_mem_stage_sram;

  logic        clk = 1'b0;
  logic        rst;
  logic        WB_En_in, MEM_R_En_in, MEM_W_En_in;
  logic [4:0]  dest_in;
  logic [31:0] ALU_result_in, readdata_in;
  logic        WB_En, MEM_R_En;
  logic [4:0]  dest;
  logic [31:0] ALU_result, mem_data;
  logic        freeze;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_WE_N;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;

  int unsigned n_cmp = 0;
  int unsigned n_mis = 0;

  always #5 clk = ~clk;

  mem_stage_sram dut (
    .clk(clk), .rst(rst),
    .WB_En_in(WB_En_in), .MEM_R_En_in(MEM_R_En_in), .MEM_W_En_in(MEM_W_En_in),
    .dest_in(dest_in), .ALU_result_in(ALU_result_in), .readdata_in(readdata_in),
    .WB_En(WB_En), .MEM_R_En(MEM_R_En), .dest(dest), .ALU_result(ALU_result),
    .mem_data(mem_data), .freeze(freeze), .SRAM_ADDR(SRAM_ADDR), .SRAM_WE_N(SRAM_WE_N),
    .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in)
  );

  // Asynchronous 16-bit SRAM: reads are combinational, and a write lands
  // at the clock edge that closes a cycle with the strobe low.
  logic [15:0] sram_mem [0:262143];
  assign sram_dq_in = sram_mem[SRAM_ADDR];
  always @(posedge clk) if (!SRAM_WE_N) sram_mem[SRAM_ADDR] <= sram_dq_out;

  // Reference: word-addressed data memory holding whole 32-bit values.
  logic [31:0] ref_mem [int];

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [16:0] word_of(input logic [31:0] a);
    logic [31:0] off;
    off = a - 32'd1024;
    return off[18:2];
  endfunction

  // Present one instruction from the EXE register and follow it to write-back.
  task automatic run_instr(input logic wb, input logic rd, input logic wr,
                           input logic [4:0] d, input logic [31:0] alu, input logic [31:0] data);
    logic [16:0] key;
    logic [31:0] exp_md;
    logic [15:0] half;
    WB_En_in = wb; MEM_R_En_in = rd; MEM_W_En_in = wr;
    dest_in = d; ALU_result_in = alu; readdata_in = data;
    if (rd || wr) begin
      key = word_of(alu);
      exp_md = 32'h0;
      if (rd && !wr && ref_mem.exists(int'(key))) exp_md = ref_mem[int'(key)];
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        check("freeze_mem", {79'h0, freeze}, {79'h0, (c < 3)});
        if (c == 1 || c == 2) begin
          half = (c == 2) ? data[31:16] : data[15:0];
          check("sram_addr", {62'h0, SRAM_ADDR}, {62'h0, key, (c == 2)});
          check("sram_ctl", {62'h0, SRAM_WE_N, sram_dq_oe, sram_dq_out},
                {62'h0, !wr, wr, (wr ? half : 16'h0)});
        end else begin
          check("sram_idle", {44'h0, SRAM_ADDR, SRAM_WE_N, sram_dq_oe, sram_dq_out},
                {44'h0, 18'h0, 1'b1, 1'b0, 16'h0});
        end
        @(posedge clk); #1;
        if (c < 3)
          check("bubble", {9'h0, WB_En, MEM_R_En, dest, ALU_result, mem_data}, 80'h0);
        else
          check("mem_result", {9'h0, WB_En, MEM_R_En, dest, ALU_result, mem_data},
                {9'h0, wb, rd, d, alu, exp_md});
      end
      if (wr) ref_mem[int'(key)] = data;
    end else begin
      @(negedge clk);
      check("freeze_alu", {79'h0, freeze}, 80'h0);
      check("sram_alu", {44'h0, SRAM_ADDR, SRAM_WE_N, sram_dq_oe, sram_dq_out},
            {44'h0, 18'h0, 1'b1, 1'b0, 16'h0});
      @(posedge clk); #1;
      check("alu_result", {9'h0, WB_En, MEM_R_En, dest, ALU_result, mem_data},
            {9'h0, wb, 1'b0, d, alu, 32'h0});
    end
  endtask

  initial begin
    logic [31:0] a;
    int unsigned kind;
    for (int i = 0; i < 262144; i++) sram_mem[i] = 16'h0;
    rst = 1'b0;
    WB_En_in = 1'b0; MEM_R_En_in = 1'b0; MEM_W_En_in = 1'b0;
    dest_in = '0; ALU_result_in = '0; readdata_in = '0;

    // Reset state, with a pending request that reset must mask.
    MEM_W_En_in = 1'b1; ALU_result_in = 32'd1028;
    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {9'h0, WB_En, MEM_R_En, dest, ALU_result, mem_data}, 80'h0);
    @(negedge clk);
    check("rst_ctl", {77'h0, freeze, SRAM_WE_N, sram_dq_oe}, {77'h0, 3'b010});
    MEM_W_En_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    // Directed cases.
    run_instr(1'b1, 1'b0, 1'b0, 5'd5, 32'd7, 32'h0);
    run_instr(1'b0, 1'b0, 1'b1, 5'd0, 32'd1028, 32'hDEADBEEF);
    run_instr(1'b1, 1'b1, 1'b0, 5'd3, 32'd1028, 32'h0);
    check("load_literal", {48'h0, mem_data}, {48'h0, 32'hDEADBEEF});
    run_instr(1'b0, 1'b0, 1'b1, 5'd0, 32'd1032, 32'h12345678);
    run_instr(1'b1, 1'b1, 1'b0, 5'd8, 32'd1032, 32'h0);
    run_instr(1'b1, 1'b1, 1'b0, 5'd9, 32'd1028, 32'h0);
    run_instr(1'b1, 1'b1, 1'b1, 5'd4, 32'd1024, 32'hCAFEF00D);
    run_instr(1'b1, 1'b1, 1'b0, 5'd6, 32'd1024, 32'h0);
    // Wrap: 1024 + 2^19 aliases word 0, and 1020 maps to the top word.
    run_instr(1'b1, 1'b1, 1'b0, 5'd7, 32'd1024 + 32'h80000, 32'h0);
    run_instr(1'b0, 1'b0, 1'b1, 5'd0, 32'd1020, 32'hA5A55A5A);
    run_instr(1'b1, 1'b1, 1'b0, 5'd1, 32'd1020, 32'h0);

    // Reset asserted during HI of a store to a word that is never read back.
    WB_En_in = 1'b0; MEM_R_En_in = 1'b0; MEM_W_En_in = 1'b1;
    ALU_result_in = 32'd1024 + 32'd400; readdata_in = 32'h11112222;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_hi_ctl", {77'h0, freeze, SRAM_WE_N, sram_dq_oe}, {77'h0, 3'b010});
    @(posedge clk); #1;
    check("rst_hi_outs", {9'h0, WB_En, MEM_R_En, dest, ALU_result, mem_data}, 80'h0);
    rst = 1'b1; MEM_W_En_in = 1'b0; ALU_result_in = 32'd0;
    @(negedge clk);
    check("post_rst_idle", {77'h0, freeze, SRAM_WE_N, sram_dq_oe}, {77'h0, 3'b010});
    @(posedge clk); #1;

    // Randomized mix over a small address pool so loads hit earlier stores.
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 3);
      a = 32'd1024 + 32'($urandom_range(0, 7)) * 4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a + 32'h80000;
      case (kind)
        0: run_instr(1'($urandom), 1'b0, 1'b0, 5'($urandom), $urandom, $urandom);
        1: run_instr(1'($urandom), 1'b1, 1'b0, 5'($urandom), a, $urandom);
        2: run_instr(1'($urandom), 1'b0, 1'b1, 5'($urandom), a, $urandom);
        default: run_instr(1'($urandom), 1'b1, 1'b1, 5'($urandom), a, $urandom);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram.md
MEM_STAGE_SRAM -- requirements
Module: mem_stage_sram

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, named as follows: clk  in  1  clock, all state on rising edge.
REQ-002 rst  in  1  synchronous active-low reset.
REQ-003 WB_En_in, MEM_R_En_in, MEM_W_En_in  in  1 each  control bits from the EXE stage register.
REQ-004 dest_in  in  5  destination register number.
REQ-005 ALU_result_in  in  32  ALU result; byte address for loads and stores.
REQ-006 readdata_in  in  32  store data (rt value).
REQ-007 WB_En, MEM_R_En  out  1 each  registered control bits to write-back.
REQ-008 dest  out  5  registered destination.
REQ-009 ALU_result  out  32  registered ALU result.
REQ-010 mem_data  out  32  registered load data.
REQ-011 freeze  out  1  combinational stall to all upstream stages and the EXE register; 1 means hold.
REQ-012 SRAM_ADDR  out  18  external SRAM halfword address.
REQ-013 SRAM_WE_N  out  1  SRAM write strobe, active low.
REQ-014 sram_dq_out  out  16  write data; sram_dq_oe  out  1  drive enable; sram_dq_in  in  16  read data (asynchronous SRAM, valid same cycle).

Function
REQ-015 Data memory base SHALL be 1024: word = (ALU_result_in - 1024)[18:2] (17 bits); SRAM_ADDR = {word, half}, half 0 = bits [15:0], half 1 = bits [31:16]; out-of-range addresses wrap mod 2^18 with no error.
REQ-016 The FSM SHALL have states IDLE, LO, HI, DONE.
REQ-017 IDLE -> LO when MEM_R_En_in or MEM_W_En_in is 1; otherwise it stays in IDLE.
REQ-018 The FSM SHALL advance LO -> HI -> DONE -> IDLE unconditionally; DONE never starts a new access.
REQ-019 freeze SHALL be 1 in IDLE-with-request, LO and HI, and 0 in IDLE-without-request and DONE; a memory access therefore stalls exactly 3 cycles.
REQ-020 LO/HI read: SRAM_ADDR = {word, 0/1}, SRAM_WE_N = 1, sram_dq_oe = 0, and sram_dq_in is captured into the low/high half of an internal buffer at the end of the state.
REQ-021 LO/HI write: SRAM_ADDR = {word, 0/1}, SRAM_WE_N = 0, sram_dq_oe = 1, and sram_dq_out = readdata_in[15:0] / [31:16].
REQ-022 Outside LO/HI: SRAM_WE_N = 1, sram_dq_oe = 0, SRAM_ADDR = 0, sram_dq_out = 0.
REQ-023 If MEM_R_En_in and MEM_W_En_in are both 1, the access SHALL be treated as a write, and mem_data loads 0 at DONE.
REQ-024 Output register, each edge with freeze = 0: WB_En, MEM_R_En, dest and ALU_result load their inputs; mem_data loads the buffer (in DONE after a read), else 0.
REQ-025 Each edge with freeze = 1: output register SHALL load a bubble (WB_En = 0, MEM_R_En = 0, dest = 0, ALU_result = 0, mem_data = 0).
REQ-026 A non-memory instruction SHALL pass with 1-cycle latency and no stall.
REQ-027 Back-to-back memory instructions: the second SHALL be detected in the IDLE cycle following DONE.

Reset
REQ-028 When rst = 0 at an edge: FSM -> IDLE; all registered outputs and the buffer -> 0.
REQ-029 While rst = 0: freeze = 0, SRAM_WE_N = 1, sram_dq_oe = 0.
REQ-030 Reset mid-access SHALL abort the access with no further SRAM strobes.

Verification
REQ-031 ALU op, WB_En_in = 1, dest_in = 5, ALU_result_in = 7 -> next edge: WB_En = 1, dest = 5, ALU_result = 7, freeze never 1.
REQ-032 Store, ALU_result_in = 1028, readdata_in = 0xDEADBEEF -> freeze 1 for 3 cycles; SRAM_ADDR 2 with WE_N = 0 and dq 0xBEEF, then SRAM_ADDR 3 with WE_N = 0 and dq 0xDEAD; at DONE edge WB_En = 0.
REQ-033 Load from 1028 after REQ-032 (SRAM model) -> mem_data = 0xDEADBEEF, MEM_R_En = 1 at DONE edge; bubbles (WB_En = 0) during freeze.
REQ-034 Two consecutive loads -> each stalls 3 cycles; both results delivered in order, no lost or duplicated write-back.
REQ-035 rst = 0 asserted during HI of a store -> next edge: IDLE, WE_N = 1, freeze = 0, all outputs 0.
REQ-036 MEM_R_En_in = MEM_W_En_in = 1, address 1024 -> two write strobes, mem_data = 0 at DONE.
